sha_msg_schedule: RTL

- SHA-256 message-schedule generator, the producer side of the per-round interface consumed by the compression-round block.
- Accepts one 512-bit padded block and emits 64 consecutive (W[t], K[t]) pairs, one per enabled cycle, together with the enable strobe that advances the compression block.
- Sits between the block-assembly/nonce logic and the compression datapath in the miner core.

---
 rtl/sha_pkg.sv | 61 ++++++
 rtl/sha_msg_schedule.sv | 87 ++++++++
 2 files changed

// File: rtl/sha_pkg.sv
// Shared SHA-256 types, round constants and bit-mixing functions used by the
// message schedule and the compression datapath.
package sha_pkg;

    typedef logic [31:0] sha_word_t;

    typedef enum logic [1:0] {
        SCHED_IDLE,
        SCHED_RUN,
        SCHED_DONE
    } sched_state_e;

    localparam sha_word_t SHA256_K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic sha_word_t rotr(input sha_word_t x, input int unsigned n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic sha_word_t sig0(input sha_word_t x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic sha_word_t sig1(input sha_word_t x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    // Compression-side mixing functions, kept here so both halves share one source.
    function automatic sha_word_t SIG0(input sha_word_t x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic sha_word_t SIG1(input sha_word_t x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic sha_word_t ch(input sha_word_t e, input sha_word_t f, input sha_word_t g);
        return (e & f) ^ (~e & g);
    endfunction

    function automatic sha_word_t maj(input sha_word_t a, input sha_word_t b, input sha_word_t c);
        return (a & b) ^ (a & c) ^ (b & c);
    endfunction

endpackage

// File: rtl/sha_msg_schedule.sv
// SHA-256 message schedule: loads one padded block and streams (W[t], K[t])
// with a round strobe to the compression datapath, using a 16-word sliding window.
module sha_msg_schedule
    import sha_pkg::*;
#(
    parameter int ROUNDS = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [511:0] block_in,
    input  logic         hold,
    output logic         enable,
    output sha_word_t    w_i,
    output sha_word_t    k_i,
    output logic [5:0]   round,
    output logic         busy,
    output logic         done
);

    localparam logic [5:0] LAST_ROUND = 6'(ROUNDS - 1);

    sched_state_e state;
    sched_state_e state_next;
    sha_word_t    win [16];
    sha_word_t    win_next;

    assign win_next = sig1(win[14]) + win[9] + sig0(win[1]) + win[0];

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        enable     = 1'b0;
        done       = 1'b0;
        case (state)
            SCHED_IDLE: begin
                if (start) begin
                    state_next = SCHED_RUN;
                end
            end
            SCHED_RUN: begin
                busy   = 1'b1;
                enable = ~hold;
                if (!hold && round == LAST_ROUND) begin
                    state_next = SCHED_DONE;
                end
            end
            SCHED_DONE: begin
                done       = 1'b1;
                state_next = SCHED_IDLE;
            end
            default: begin
                state_next = SCHED_IDLE;
            end
        endcase
    end

    // Outputs are forced to zero whenever the compression side is not being advanced.
    assign w_i = enable ? win[0] : '0;
    assign k_i = enable ? SHA256_K[round] : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= SCHED_IDLE;
            round <= '0;
            for (int j = 0; j < 16; j++) begin
                win[j] <= '0;
            end
        end else begin
            state <= state_next;
            if (state == SCHED_IDLE && start) begin
                round <= '0;
                for (int j = 0; j < 16; j++) begin
                    win[j] <= block_in[511 - 32*j -: 32];
                end
            end else if (enable) begin
                // The oldest word leaves as it is consumed; the new tail word is W[t+16].
                for (int j = 0; j < 15; j++) begin
                    win[j] <= win[j + 1];
                end
                win[15] <= win_next;
                round   <= (round == LAST_ROUND) ? 6'd0 : round + 6'd1;
            end
        end
    end

endmodule
